clfsr_stream_cipher: RTL
========================

Name: clfsr_stream_cipher

Overview:
- Parametrised successor to the fixed-size RGB encryption loop.
- Streams `LEN` pixels of `NCH` colour channels from an external source memory, combines each channel byte with a per-channel chaotic-LFSR keystream word, and writes the result to an external destination memory.
- Supports an encrypt or decrypt direction and an add/sub or XOR combine mode.
- Keystream flow control is a valid/ready handshake.
- Sits between the CLFSR key generators and the image BRAMs.

Parameters:
- `DATA_W`, 8, bits per channel sample.
- `NCH`, 3, number of colour channels processed in parallel.
- `ADDR_W`, 14, memory address width; maximum image depth is 2**`ADDR_W` pixels.

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `start`  input  1  one-cycle pulse that begins a job; sampled only in IDLE or DONE.
- `len`  input  `ADDR_W`+1  number of pixels in the job, sampled with `start`; legal range 0..2**`ADDR_W`.
- `decrypt`  input  1  direction, sampled with `start`: 0 = encrypt, 1 = decrypt.
- `xor_mode`  input  1  combine mode, sampled with `start`: 0 = modular add/sub, 1 = XOR.
- `key_valid`  input  1  keystream word on `key_data` is valid.
- `key_data`  input  `NCH`*`DATA_W`  keystream; channel c occupies bits [c*`DATA_W` +: `DATA_W`].
- `key_ready`  output  1  keystream word consumed this cycle.
- `rd_en`  output  1  source memory read strobe.
- `rd_addr`  output  `ADDR_W`  source read address.
- `rd_data`  input  `NCH`*`DATA_W`  source data; valid exactly 1 cycle after `rd_en`.
- `wr_en`  output  1  destination write strobe.
- `wr_addr`  output  `ADDR_W`  destination write address.
- `wr_data`  output  `NCH`*`DATA_W`  processed pixel, same channel packing as `key_data`.
- `busy`  output  1  high in RUN and DRAIN.
- `done`  output  1  level; high in DONE until the next accepted `start` or reset.

Behaviour:
- Reset (`rst`=0 at a clock edge):
  - state goes to IDLE, the pipeline is flushed, and all in-flight data is discarded.
  - `key_ready`, `rd_en`, `wr_en`, `busy` and `done` = 0.
  - `rd_addr`, `wr_addr` and `wr_data` = 0.
  - Reset mid-job aborts the job; no further writes occur.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE: on `start`, latch `len`, `decrypt` and `xor_mode`, and clear `done`.
    - If `len`=0, go directly to DONE; `done` rises the next cycle and no memory access occurs.
    - Otherwise go to RUN with the issue counter = 0.
  - RUN: each cycle in which `key_valid`=1 is an issue.
    - `key_ready`=1, `rd_en`=1, `rd_addr` = issue counter.
    - Latch `key_data` into the stage-1 key register; increment the issue counter.
    - When `key_valid`=0: `key_ready`=0, `rd_en`=0, and nothing advances (stall).
    - The issue of pixel `len`-1 moves the FSM to DRAIN.
  - DRAIN: no issues and `key_ready`=0. Wait until the last write has been performed, then go to DONE.
  - `start` while `busy` is ignored.
- Pipeline: issue at cycle t; `rd_data` arrives at t+1; `wr_en`/`wr_addr`/`wr_data` are registered and asserted at t+2. Throughput is 1 pixel/cycle with a continuous keystream.
- Per-channel arithmetic, mod 2**`DATA_W`, with no carry between channels:
  - xor_mode=1: `wr_data` = `rd_data` ^ key, for either direction.
  - xor_mode=0, encrypt: `wr_data` = `rd_data` + key, truncated.
  - xor_mode=0, decrypt: `wr_data` = `rd_data` - key, truncated (borrow wraps).
- `wr_addr` equals the `rd_addr` of the same pixel. Writes occur in strictly ascending address order, 0..`len`-1, each exactly once.
- `done` rises on the cycle after the final `wr_en` and stays high.
- `len` = 2**`ADDR_W`: the issue counter is `ADDR_W`+1 bits wide, and the address wraps only after the last pixel, with no extra write.
- Keystream stalls mid-job change only the timing, never the data or the ordering.
- Mode inputs changing during a job have no effect.

Test Plan:
- Encrypt, add mode, `len`=4, source {0x10,0x20,0x30}×4, constant key {0x05,0xF0,0x01}, `key_valid` held high → 4 writes on consecutive cycles, first write 2 cycles after first issue, `wr_data` = {0x15,0x10,0x31}; `done`=1 one cycle after last write.
- Decrypt, add mode on the output of the first scenario with the same key → `wr_data` restores {0x10,0x20,0x30}; borrow case 0x10-0xF0 = 0x20 verified per channel.
- XOR mode, pixel 0xAA55C3, key 0xFF00FF → 0x55553C; decrypt with the same key returns 0xAA55C3.
- `key_valid` toggling 1,0,0,1,1 with `len`=3 → exactly 3 reads/writes at addresses 0,1,2; `key_ready` only when valid; no write during stall gaps.
- `len`=0 → no `rd_en`/`wr_en`, `done`=1 the cycle after `start`; `start` pulsed while `busy` → ignored.
- Reset asserted (`rst`=0) mid-RUN at pixel 2 of 8 → all outputs 0 the following cycle, no later writes; a new `start` with `len`=2^`ADDR_W` (default 16384) completes with the last `wr_addr`=16383 and a single `done`.

Source files
------------

// File: rtl/clfsr_stream_cipher.sv
// Streams LEN multi-channel pixels from a source memory, combines each channel
// with a chaotic-LFSR keystream word (add/sub or XOR) and writes a destination memory.
module clfsr_stream_cipher #(
    parameter int DATA_W = 8,
    parameter int NCH    = 3,
    parameter int ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W:0]       len,
    input  logic                  decrypt,
    input  logic                  xor_mode,
    input  logic                  key_valid,
    input  logic [NCH*DATA_W-1:0] key_data,
    output logic                  key_ready,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [NCH*DATA_W-1:0] rd_data,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [NCH*DATA_W-1:0] wr_data,
    output logic                  busy,
    output logic                  done
);

    localparam int PIX_W = NCH * DATA_W;
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    logic [ADDR_W:0]    len_q;
    logic               dec_q;
    logic               xor_q;
    logic [ADDR_W:0]    issue_cnt;
    logic               s1_valid;
    logic [PIX_W-1:0]   s1_key;
    logic [ADDR_W-1:0]  s1_addr;
    logic [PIX_W-1:0]   comb;
    logic               issue;

    // The keystream handshake and memory read must respond in the same cycle as key_valid.
    assign issue     = (state == RUN) && key_valid;
    assign key_ready = issue;
    assign rd_en     = issue;
    assign rd_addr   = issue_cnt[ADDR_W-1:0];
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);

    always_comb begin
        comb = '0;
        for (int c = 0; c < NCH; c++) begin
            if (xor_q)
                comb[c*DATA_W +: DATA_W] = rd_data[c*DATA_W +: DATA_W] ^ s1_key[c*DATA_W +: DATA_W];
            else if (dec_q)
                comb[c*DATA_W +: DATA_W] = rd_data[c*DATA_W +: DATA_W] - s1_key[c*DATA_W +: DATA_W];
            else
                comb[c*DATA_W +: DATA_W] = rd_data[c*DATA_W +: DATA_W] + s1_key[c*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            len_q     <= '0;
            dec_q     <= 1'b0;
            xor_q     <= 1'b0;
            issue_cnt <= '0;
            s1_valid  <= 1'b0;
            s1_key    <= '0;
            s1_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            // Stage 2: rd_data for the stage-1 pixel is present this cycle.
            wr_en <= s1_valid;
            if (s1_valid) begin
                wr_addr <= s1_addr;
                wr_data <= comb;
            end
            s1_valid <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len_q     <= len;
                        dec_q     <= decrypt;
                        xor_q     <= xor_mode;
                        issue_cnt <= '0;
                        state     <= (len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (key_valid) begin
                        s1_valid  <= 1'b1;
                        s1_key    <= key_data;
                        s1_addr   <= issue_cnt[ADDR_W-1:0];
                        issue_cnt <= issue_cnt + ONE;
                        if (issue_cnt == len_q - ONE)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Last write is on the bus and nothing is left in stage 1.
                    if (wr_en && !s1_valid)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
